// File: rtl/waterfall_pkg.sv
// Shared constants and slot-to-RAM mapping for the spectrogram waterfall address path.
package waterfall_pkg;

    localparam int unsigned DEF_BINS           = 128;
    localparam int unsigned DEF_RAM_ADDR_WIDTH = 12;
    localparam int unsigned DEF_NO_FFTS        = 50;

    localparam int unsigned BIN_W         = $clog2(DEF_BINS);
    localparam int unsigned FFT_IDX_W     = $clog2(DEF_NO_FFTS);
    localparam int unsigned FFTS_PER_BANK = 2 ** (DEF_RAM_ADDR_WIDTH - BIN_W);

    typedef struct packed {
        logic [31:0] bank;
        logic [31:0] addr;
    } bank_addr_t;

    // Each bank holds 2^(ram_addr_width-bin_w) FFT rows of 2^bin_w bins.
    function automatic bank_addr_t slot_to_bank_addr(input int unsigned slot,
                                                     input int unsigned bin,
                                                     input int unsigned bin_w,
                                                     input int unsigned ram_addr_width);
        int unsigned fpb_log2;
        bank_addr_t  r;
        fpb_log2 = ram_addr_width - bin_w;
        r.bank   = slot >> fpb_log2;
        r.addr   = ((slot & ((32'd1 << fpb_log2) - 32'd1)) << bin_w) | bin;
        return r;
    endfunction

endpackage

// File: rtl/waterfall_addr_gen_if.sv
// Pixel-side request and RAM-side read-select bundle of the waterfall address generator.
interface waterfall_addr_gen_if #(
    parameter int unsigned COORDW         = 16,
    parameter int unsigned NO_BANKS       = 2,
    parameter int unsigned RAM_ADDR_WIDTH = 12
);
    logic [COORDW-1:0]         x;
    logic [COORDW-1:0]         y;
    logic                      pix_valid;
    logic                      frame_start;
    logic [NO_BANKS-1:0]       rd_bank_select;
    logic [RAM_ADDR_WIDTH-1:0] rd_address;
    logic                      rd_valid;
    logic                      rd_in_window;

    modport master (
        output x, y, pix_valid, frame_start,
        input  rd_bank_select, rd_address, rd_valid, rd_in_window
    );

    modport slave (
        input  x, y, pix_valid, frame_start,
        output rd_bank_select, rd_address, rd_valid, rd_in_window
    );
endinterface

// File: rtl/waterfall_addr_gen_fft_ring_ptr.sv
// FFT history ring pointer with a per-frame snapshot so a displayed frame never tears.
module fft_ring_ptr #(
    parameter int unsigned NO_FFTS = 50,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fft_commit,
    input  logic             frame_start,
    output logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] oldest_idx,
    output logic [IDX_W-1:0] oldest_snap,
    output logic [IDX_W-1:0] newest_snap,
    output logic [CNT_W-1:0] filled_snap
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NO_FFTS - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NO_FFTS);

    logic [CNT_W-1:0] filled;
    logic [IDX_W-1:0] newest;

    always_comb begin
        oldest_idx = (filled == FULL) ? wr_idx : '0;
        newest     = (wr_idx == '0) ? LAST : wr_idx - IDX_W'(1);
    end

    // Snapshot samples the registered (pre-commit) values when both pulses coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx      <= '0;
            filled      <= '0;
            oldest_snap <= '0;
            newest_snap <= '0;
            filled_snap <= '0;
        end else begin
            if (fft_commit) begin
                wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + IDX_W'(1);
                if (filled != FULL)
                    filled <= filled + CNT_W'(1);
            end
            if (frame_start) begin
                oldest_snap <= oldest_idx;
                newest_snap <= newest;
                filled_snap <= filled;
            end
        end
    end
endmodule

// File: rtl/waterfall_addr_gen.sv
// Three-stage display-coordinate to FFT-history bank/address translator.
module waterfall_addr_gen
    import waterfall_pkg::*;
#(
    parameter int unsigned NO_BANKS       = 2,
    parameter int unsigned COORDW         = 16,
    parameter int unsigned RAM_ADDR_WIDTH = 12,
    parameter int unsigned NO_FFTS        = 50,
    parameter int unsigned BINS           = 128,
    parameter int unsigned X_SCALE_LOG2   = 2,
    parameter int unsigned Y_SCALE_LOG2   = 4,
    parameter int unsigned H_BIAS         = 64,
    parameter int unsigned V_BIAS         = 60,
    parameter int unsigned NEWEST_ON_TOP  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    waterfall_addr_gen_if.slave        pix,
    input  logic                       fft_commit,
    output logic [$clog2(NO_FFTS)-1:0] wr_fft_idx,
    output logic [$clog2(NO_FFTS)-1:0] oldest_idx
);
    localparam int unsigned IDX_W  = $clog2(NO_FFTS);
    localparam int unsigned CNT_W  = $clog2(NO_FFTS + 1);
    localparam int unsigned BW     = $clog2(BINS);
    localparam logic [IDX_W:0] NF  = (IDX_W + 1)'(NO_FFTS);

    logic [IDX_W-1:0] oldest_snap, newest_snap;
    logic [CNT_W-1:0] filled_snap;

    fft_ring_ptr #(
        .NO_FFTS (NO_FFTS),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .fft_commit  (fft_commit),
        .frame_start (pix.frame_start),
        .wr_idx      (wr_fft_idx),
        .oldest_idx  (oldest_idx),
        .oldest_snap (oldest_snap),
        .newest_snap (newest_snap),
        .filled_snap (filled_snap)
    );

    // S1: window test; the extra MSB of dx/dy flags coordinates left of / above the window.
    logic [COORDW:0]   dx, dy;
    logic [COORDW-1:0] col, row;
    logic              win1;

    always_comb begin
        dx   = {1'b0, pix.x} - (COORDW + 1)'(H_BIAS);
        dy   = {1'b0, pix.y} - (COORDW + 1)'(V_BIAS);
        col  = dx[COORDW-1:0] >> X_SCALE_LOG2;
        row  = dy[COORDW-1:0] >> Y_SCALE_LOG2;
        win1 = pix.pix_valid & ~dx[COORDW] & ~dy[COORDW]
             & (col < COORDW'(BINS)) & (row < COORDW'(filled_snap));
    end

    logic             s1_valid, s1_win;
    logic [IDX_W-1:0] s1_row;
    logic [BW-1:0]    s1_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_win   <= 1'b0;
            s1_row   <= '0;
            s1_bin   <= '0;
        end else begin
            s1_valid <= pix.pix_valid;
            s1_win   <= win1;
            s1_row   <= row[IDX_W-1:0];
            s1_bin   <= col[BW-1:0];
        end
    end

    // S2: row to ring slot; row < NO_FFTS so a single correction suffices.
    logic [IDX_W:0]   sum, diff;
    logic [IDX_W-1:0] slot2;

    always_comb begin
        sum  = {1'b0, oldest_snap} + {1'b0, s1_row};
        if (sum >= NF)
            sum = sum - NF;
        diff = {1'b0, newest_snap} - {1'b0, s1_row};
        if (diff[IDX_W])
            diff = diff + NF;
        slot2 = (NEWEST_ON_TOP != 0) ? diff[IDX_W-1:0] : sum[IDX_W-1:0];
    end

    logic             s2_valid, s2_win;
    logic [IDX_W-1:0] s2_slot;
    logic [BW-1:0]    s2_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_win   <= 1'b0;
            s2_slot  <= '0;
            s2_bin   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_win   <= s1_win;
            s2_slot  <= slot2;
            s2_bin   <= s1_bin;
        end
    end

    // S3: bank decode and output registers.
    bank_addr_t          ba;
    logic [NO_BANKS-1:0] bank_oh;
    logic                unused_ba_bits;

    always_comb begin
        ba      = slot_to_bank_addr(32'(s2_slot), 32'(s2_bin), BW, RAM_ADDR_WIDTH);
        bank_oh = '0;
        for (int unsigned b = 0; b < NO_BANKS; b++)
            bank_oh[b] = (ba.bank == b);
        unused_ba_bits = ^ba.addr[31:RAM_ADDR_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix.rd_bank_select <= '0;
            pix.rd_address     <= '0;
            pix.rd_in_window   <= 1'b0;
            pix.rd_valid       <= 1'b0;
        end else begin
            pix.rd_bank_select <= s2_win ? bank_oh : '0;
            pix.rd_address     <= s2_win ? ba.addr[RAM_ADDR_WIDTH-1:0] : '0;
            pix.rd_in_window   <= s2_win;
            pix.rd_valid       <= s2_valid;
        end
    end
endmodule
